// File: rtl/td_pkg.sv
// Shared definitions for the tone-detection interface: direction codes seen by the
// drive state machine, decoder FSM states, and the window-code decode helpers.
package td_pkg;

    typedef enum logic [1:0] {
        DIR_STRAIGHT = 2'b00,
        DIR_LEFT     = 2'b01,
        DIR_RIGHT    = 2'b10,
        DIR_BACK     = 2'b11
    } td_dir_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CANDIDATE = 2'd1,
        ST_LOCKED    = 2'd2
    } td_state_e;

    localparam int NUM_CH = 5;   // bp1..bp4 directions, bp5 noise guard
    localparam int CNT_W  = 12;  // per-channel edge counter width

    // A window is usable only with exactly one direction tone and a quiet guard channel.
    function automatic logic code_valid(input logic [NUM_CH-1:0] pres);
        return !pres[4] && ($countones(pres[3:0]) == 1);
    endfunction

    function automatic td_dir_e code_of(input logic [NUM_CH-1:0] pres);
        td_dir_e c;
        c = DIR_STRAIGHT;
        if (pres[1])      c = DIR_LEFT;
        else if (pres[2]) c = DIR_RIGHT;
        else if (pres[3]) c = DIR_BACK;
        return c;
    endfunction

endpackage

// File: rtl/tone_channel_counter.sv
// One comparator channel: synchronizer, rising-edge detect, saturating edge counter,
// and the present decision for the window that is closing.
module tone_channel_counter
    import td_pkg::*;
#(
    parameter int MIN_EDGES = 8,
    parameter int MAX_EDGES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic bp,
    input  logic win_close,
    output logic present
);

    logic [1:0]       r_sync;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             w_edge;
    logic [CNT_W-1:0] w_total;

    assign w_edge  = r_sync[1] & ~r_prev;
    // An edge seen on the close cycle still belongs to the closing window.
    assign w_total = (w_edge && (r_cnt != '1)) ? r_cnt + 1'b1 : r_cnt;
    assign present = (int'(w_total) >= MIN_EDGES) && (int'(w_total) <= MAX_EDGES);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], bp};
            r_prev <= r_sync[1];
            r_cnt  <= win_close ? '0 : w_total;
        end
    end

endmodule

// File: rtl/tone_decoder.sv
// Measures edge rate on five bandpass channels per window and locks a direction
// once a single tone has been stable for several consecutive windows.
module tone_decoder
    import td_pkg::*;
#(
    parameter int WINDOW_CYCLES   = 500_000,
    parameter int MIN_EDGES       = 8,
    parameter int MAX_EDGES       = 64,
    parameter int CONFIRM_WINDOWS = 3,
    parameter int RELEASE_WINDOWS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bp1,
    input  logic       bp2,
    input  logic       bp3,
    input  logic       bp4,
    input  logic       bp5,
    output logic       tdEn,
    output logic [1:0] tdDir,
    output logic [4:0] tdChan
);

    localparam int WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int CONF_W = $clog2(CONFIRM_WINDOWS + 1);
    localparam int MISS_W = $clog2(RELEASE_WINDOWS + 1);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CONF_W-1:0] CONF_N   = CONF_W'(CONFIRM_WINDOWS);
    localparam logic [MISS_W-1:0] MISS_N   = MISS_W'(RELEASE_WINDOWS);

    logic [WIN_W-1:0]  r_win;
    logic              w_close;
    logic [NUM_CH-1:0] w_bp;
    logic [NUM_CH-1:0] w_pres;
    logic [NUM_CH-1:0] r_chan;
    logic              w_valid;
    td_dir_e           w_code;

    td_state_e         r_state, w_state;
    td_dir_e           r_cand, w_cand;
    td_dir_e           r_dir, w_dir;
    logic [CONF_W-1:0] r_conf, w_conf, w_conf_inc;
    logic [MISS_W-1:0] r_miss, w_miss, w_miss_inc;

    assign w_bp    = {bp5, bp4, bp3, bp2, bp1};
    assign w_close = (r_win == WIN_LAST);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tone_channel_counter #(
            .MIN_EDGES (MIN_EDGES),
            .MAX_EDGES (MAX_EDGES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .bp        (w_bp[g]),
            .win_close (w_close),
            .present   (w_pres[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || w_close) r_win <= '0;
        else                r_win <= r_win + 1'b1;
    end

    assign w_valid    = code_valid(w_pres);
    assign w_code     = code_of(w_pres);
    assign w_conf_inc = r_conf + 1'b1;
    assign w_miss_inc = r_miss + 1'b1;

    always_comb begin
        w_state = r_state;
        w_cand  = r_cand;
        w_dir   = r_dir;
        w_conf  = r_conf;
        w_miss  = r_miss;
        if (w_close) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        w_cand = w_code;
                        w_conf = CONF_W'(1);
                        if (CONFIRM_WINDOWS == 1) begin
                            w_state = ST_LOCKED;
                            w_dir   = w_code;
                            w_miss  = '0;
                        end else begin
                            w_state = ST_CANDIDATE;
                        end
                    end
                end
                ST_CANDIDATE: begin
                    if (!w_valid) begin
                        w_state = ST_IDLE;
                        w_conf  = '0;
                    end else if (w_code != r_cand) begin
                        w_cand = w_code;
                        w_conf = CONF_W'(1);
                    end else begin
                        w_conf = w_conf_inc;
                        if (w_conf_inc == CONF_N) begin
                            w_state = ST_LOCKED;
                            w_dir   = r_cand;
                            w_miss  = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    // A different tone only counts as a miss; switching goes via IDLE.
                    if (w_valid && (w_code == r_cand)) begin
                        w_miss = '0;
                    end else if (w_miss_inc == MISS_N) begin
                        w_state = ST_IDLE;
                        w_miss  = '0;
                        w_conf  = '0;
                    end else begin
                        w_miss = w_miss_inc;
                    end
                end
                default: w_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cand  <= DIR_STRAIGHT;
            r_dir   <= DIR_STRAIGHT;
            r_conf  <= '0;
            r_miss  <= '0;
            r_chan  <= '0;
        end else begin
            r_state <= w_state;
            r_cand  <= w_cand;
            r_dir   <= w_dir;
            r_conf  <= w_conf;
            r_miss  <= w_miss;
            if (w_close) r_chan <= w_pres;
        end
    end

    assign tdEn   = (r_state == ST_LOCKED);
    assign tdDir  = r_dir;
    assign tdChan = r_chan;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder: square-wave tones per channel, a window-level
// reference model compared every cycle, and literal checks at key window closes.
module tb_tone_decoder;

    localparam int W    = 1000;
    localparam int MINE = 4;
    localparam int MAXE = 20;
    localparam int CONF = 3;
    localparam int REL  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] bp  = '0;
    logic       tdEn;
    logic [1:0] tdDir;
    logic [4:0] tdChan;

    int n_tests = 0;
    int n_fail  = 0;
    int per[5];
    int tcnt    = 0;
    int cyc     = 0;
    bit chk_en  = 0;

    always #5 clk = ~clk;

    tone_decoder #(
        .WINDOW_CYCLES   (W),
        .MIN_EDGES       (MINE),
        .MAX_EDGES       (MAXE),
        .CONFIRM_WINDOWS (CONF),
        .RELEASE_WINDOWS (REL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bp1    (bp[0]),
        .bp2    (bp[1]),
        .bp3    (bp[2]),
        .bp4    (bp[3]),
        .bp5    (bp[4]),
        .tdEn   (tdEn),
        .tdDir  (tdDir),
        .tdChan (tdChan)
    );

    // Tone generators: per[i] == 0 keeps the channel low.
    always @(negedge clk) begin
        tcnt++;
        for (int i = 0; i < 5; i++)
            bp[i] = (per[i] != 0) && ((tcnt % per[i]) >= per[i] / 2);
    end

    // Reference model: an input rising edge is counted 2 sync cycles later, each
    // window's edge tallies decide presence, then the lock rules run per window.
    int   m_hist[5][3];
    int   m_cnt[5];
    int   m_wpos;
    int   m_state;   // 0 idle, 1 candidate, 2 locked
    int   m_cand, m_conf, m_miss, m_dir;
    logic [4:0] m_chan;

    always @(posedge clk) begin
        if (rst) begin
            cyc = 0;
            for (int i = 0; i < 5; i++) begin
                m_cnt[i] = 0;
                for (int j = 0; j < 3; j++) m_hist[i][j] = 0;
            end
            m_wpos = 0; m_state = 0; m_cand = 0; m_conf = 0; m_miss = 0; m_dir = 0;
            m_chan = '0;
        end else begin
            int npres, code;
            bit valid;
            cyc++;
            for (int i = 0; i < 5; i++) begin
                if (m_hist[i][1] == 1 && m_hist[i][2] == 0) m_cnt[i]++;
                m_hist[i][2] = m_hist[i][1];
                m_hist[i][1] = m_hist[i][0];
                m_hist[i][0] = int'(bp[i]);
            end
            if (m_wpos == W - 1) begin
                npres = 0;
                code  = 0;
                for (int i = 0; i < 5; i++) m_chan[i] = (m_cnt[i] >= MINE) && (m_cnt[i] <= MAXE);
                for (int i = 0; i < 4; i++) if (m_chan[i]) begin npres++; code = i; end
                valid = (npres == 1) && !m_chan[4];
                case (m_state)
                    0: if (valid) begin
                        m_cand = code; m_conf = 1;
                        if (CONF == 1) begin m_state = 2; m_dir = code; m_miss = 0; end
                        else m_state = 1;
                    end
                    1: if (!valid) m_state = 0;
                       else if (code != m_cand) begin m_cand = code; m_conf = 1; end
                       else begin
                           m_conf++;
                           if (m_conf == CONF) begin m_state = 2; m_dir = m_cand; m_miss = 0; end
                       end
                    default: if (valid && code == m_cand) m_miss = 0;
                       else begin
                           m_miss++;
                           if (m_miss == REL) begin m_state = 0; m_miss = 0; end
                       end
                endcase
                for (int i = 0; i < 5; i++) m_cnt[i] = 0;
                m_wpos = 0;
            end else begin
                m_wpos++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [7:0] exp_v, act_v;
            logic [1:0] md;
            md    = m_dir[1:0];
            exp_v = {(m_state == 2), md, m_chan};
            act_v = {tdEn, tdDir, tdChan};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL model cyc=%0d: {en,dir,chan} got %b expected %b", cyc, act_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Returns #1 after the n-th (0-based) clock edge since reset release.
    task automatic at_edge(input int n);
        int guard;
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (cyc < n + 1 && guard < 50000);
        if (guard >= 50000) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout waiting for edge %0d: cyc %0d", n, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_tones(input int p1, input int p2, input int p3, input int p4, input int p5);
        per[0] = p1; per[1] = p2; per[2] = p3; per[3] = p4; per[4] = p5;
    endtask

    initial begin
        set_tones(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_en = 1;
        check("reset_en",   int'(tdEn),   0);
        check("reset_dir",  int'(tdDir),  0);
        check("reset_chan", int'(tdChan), 0);

        // Lock LEFT from reset, then release hysteresis.
        set_tones(0, 100, 0, 0, 0);
        do_reset();
        at_edge(2998);
        check("left_pre_lock", int'(tdEn), 0);
        at_edge(2999);
        check("left_lock_en",   int'(tdEn),   1);
        check("left_lock_dir",  int'(tdDir),  1);
        check("left_lock_chan", int'(tdChan), 5'b00010);
        set_tones(0, 0, 0, 0, 0);
        at_edge(3999);
        check("one_silent_window", int'(tdEn), 1);
        set_tones(0, 100, 0, 0, 0);
        at_edge(5999);
        set_tones(0, 0, 0, 0, 0);
        at_edge(6999);
        check("first_miss_hold", int'(tdEn), 1);
        at_edge(7998);
        check("second_miss_pre", int'(tdEn), 1);
        at_edge(7999);
        check("release_en",  int'(tdEn),  0);
        check("release_dir", int'(tdDir), 1);

        // Reset during the second STRAIGHT confirmation window.
        set_tones(100, 0, 0, 0, 0);
        at_edge(9500);
        check("confirm_chan", int'(tdChan), 5'b00001);
        do_reset();
        check("midreset_en",   int'(tdEn),   0);
        check("midreset_dir",  int'(tdDir),  0);
        check("midreset_chan", int'(tdChan), 0);
        at_edge(2998);
        check("relock_pre", int'(tdEn), 0);
        at_edge(2999);
        check("relock_en",  int'(tdEn),  1);
        check("relock_dir", int'(tdDir), 0);

        // Two simultaneous tones never decode.
        set_tones(100, 0, 100, 0, 0);
        do_reset();
        at_edge(1000);
        check("two_tone_chan", int'(tdChan), 5'b00101);
        at_edge(9999);
        check("two_tone_en", int'(tdEn), 0);

        // Noise guard veto.
        set_tones(0, 0, 0, 100, 100);
        do_reset();
        at_edge(4999);
        check("noise_en",   int'(tdEn),   0);
        check("noise_chan", int'(tdChan), 5'b11000);

        // BACK decodes to 11.
        set_tones(0, 0, 0, 100, 0);
        do_reset();
        at_edge(3999);
        check("back_en",  int'(tdEn),  1);
        check("back_dir", int'(tdDir), 3);

        // Rate limits: too fast, too slow, and both inclusive boundaries.
        set_tones(0, 0, 20, 0, 0);
        do_reset();
        at_edge(4999);
        check("fast_en",   int'(tdEn),   0);
        check("fast_chan", int'(tdChan), 0);

        set_tones(0, 0, 400, 0, 0);
        do_reset();
        at_edge(4999);
        check("slow_en",   int'(tdEn),   0);
        check("slow_chan", int'(tdChan), 0);

        set_tones(0, 0, 250, 0, 0);
        do_reset();
        at_edge(4999);
        check("min_edges_en",   int'(tdEn),   1);
        check("min_edges_dir",  int'(tdDir),  2);
        check("min_edges_chan", int'(tdChan), 5'b00100);

        set_tones(0, 0, 50, 0, 0);
        do_reset();
        at_edge(4999);
        check("max_edges_en",   int'(tdEn),   1);
        check("max_edges_dir",  int'(tdDir),  2);
        check("max_edges_chan", int'(tdChan), 5'b00100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
